md_scheduler: RTL and testbench

Sequencing controller for the shared multiply/divide resource in the five-stage MIPS pipeline. It accepts one HI/LO operation per request from the E stage, runs it for a fixed multi-cycle latency, and owns the HI/LO registers. It also raises a stall toward the hazard logic whenever a D-stage instruction needs the multiply/divide resource while it is occupied.

---
 rtl/md_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_md_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
//
// Sequencing controller for the shared multiply/divide unit of the five-stage
// MIPS pipeline. It accepts one HI/LO operation per E-stage request, keeps the
// resource busy for a fixed number of cycles on mult/multu/div/divu, and owns
// the architectural HI/LO registers. It also raises a combinational stall to
// the hazard unit whenever a D-stage md instruction would collide with the
// resource.
//
// Parameters
//   MULT_CYCLES : busy duration of mult/multu (>= 2)
//   DIV_CYCLES  : busy duration of div/divu   (>= 2)
//
// Ports
//   clk      in  1  : rising-edge clock
//   reset    in  1  : synchronous, active-low reset
//   start    in  1  : E-stage request strobe, qualifies md_op
//   md_op    in  3  : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   A        in  32 : forwarded rs value
//   B        in  32 : forwarded rt value
//   md_use_D in  1  : D-stage instruction uses the md resource
//   busy     out 1  : a multi-cycle operation is in flight
//   HI       out 32 : architectural HI register
//   LO       out 32 : architectural LO register
//   stall_md out 1  : combinational stall request to the hazard unit
// -----------------------------------------------------------------------------
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [31:0]      a_q,     a_d;
  logic [31:0]      b_q,     b_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;

  logic [63:0]      result;
  logic             long_req;

  // 32x32 -> 64 product. Operands are extended to 64 bits first, so the low
  // 64 bits of the product are correct for both signed and unsigned forms.
  function automatic logic [63:0] mul_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
    logic [63:0] ae;
    logic [63:0] be;
    ae = {(sgn ? {32{a[31]}} : 32'd0), a};
    be = {(sgn ? {32{b[31]}} : 32'd0), b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // re-applies signs: quotient negative when signs differ, remainder takes
  // the dividend's sign. 0x80000000 / -1 falls out naturally: magnitude
  // 0x80000000 negated is 0x80000000 again, remainder 0.
  // Division by zero returns HI=dividend, LO=all ones.
  function automatic logic [63:0] div_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] res;
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ua    = (sgn & a[31]) ? (~a + 32'd1) : a;
    ub    = (sgn & b[31]) ? (~b + 32'd1) : b;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q   = ua / ub;
      r   = ua % ub;
      q   = neg_q ? (~q + 32'd1) : q;
      r   = neg_r ? (~r + 32'd1) : r;
      res = {r, q};
    end
    return res;
  endfunction

  assign long_req = start & (md_op >= OP_MULT) & (md_op <= OP_DIVU);

  // Write-back value computed from the latched operands.
  always_comb begin
    result = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  result = mul_result(a_q, b_q, 1'b1);
      OP_MULTU: result = mul_result(a_q, b_q, 1'b0);
      OP_DIV:   result = div_result(a_q, b_q, 1'b1);
      OP_DIVU:  result = div_result(a_q, b_q, 1'b0);
      default:  result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
              cnt_d   = MULT_CNT;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
              cnt_d   = DIV_CNT;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Requests arriving while running are dropped; the hazard unit
        // keeps them from happening in normal operation.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d    = result[63:32];
          lo_d    = result[31:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;
  // mthi/mtlo complete in one edge and never need to hold the D stage.
  assign stall_md = md_use_D & (busy | long_req);

endmodule

// File: tb/tb_md_scheduler.sv
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stall_md;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .md_use_D(md_use_D), .busy(busy), .HI(HI), .LO(LO), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural result {HI,LO} computed with 64-bit
  // integer arithmetic straight from the instruction definitions.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      3'd4: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'd5: res = {a, lo};
      3'd6: res = {hi, a};
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MULT_N;
    if (op == 3'd3 || op == 3'd4) return DIV_N;
    return 0;
  endfunction

  // Issues one request, scrambles the inputs afterwards, and waits (bounded)
  // for busy to drop. Reports busy cycles and whether HI/LO moved meanwhile.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int bc, output bit chg);
    logic [31:0] h0, l0;
    start = 1'b1; md_op = op; A = a; B = b;
    tick;
    start = 1'b0; md_op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
    h0 = HI; l0 = LO;
    bc = 0; chg = 1'b0;
    while (busy === 1'b1 && bc < 64) begin
      if (HI !== h0 || LO !== l0) chg = 1'b1;
      bc++;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0; md_use_D = 1'b0;
    tick; tick;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else n_pass++;
    n_checks++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else n_pass++;
    n_checks++; if (stall_md !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_md); else n_pass++;
    // Reset must win over a same-cycle mthi.
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD_0001;
    tick;
    n_checks++; if (HI !== 32'd0) $display("FAIL reset_prio_hi: got %h want 0", HI); else n_pass++;
    start = 1'b0; md_op = 3'd0;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_mult;
    int bc; bit chg;
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc, chg);
    n_checks++; if (bc != MULT_N) $display("FAIL mult_busy_len: got %0d want %0d", bc, MULT_N); else n_pass++;
    n_checks++; if (chg !== 1'b0) $display("FAIL mult_hold: HI/LO changed while busy got %b want 0", chg); else n_pass++;
    n_checks++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", HI); else n_pass++;
    n_checks++; if (LO !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h want fffffffa", LO); else n_pass++;
  endtask

  task automatic test_div;
    int bc; bit chg;
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc, chg);
    n_checks++; if (bc != DIV_N) $display("FAIL div_busy_len: got %0d want %0d", bc, DIV_N); else n_pass++;
    n_checks++; if (chg !== 1'b0) $display("FAIL div_hold: got %b want 0", chg); else n_pass++;
    n_checks++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", LO); else n_pass++;
    n_checks++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", HI); else n_pass++;
    do_op(3'd4, 32'd7, 32'd2, bc, chg);
    n_checks++; if (bc != DIV_N) $display("FAIL divu_busy_len: got %0d want %0d", bc, DIV_N); else n_pass++;
    n_checks++; if (LO !== 32'd3) $display("FAIL divu_lo: got %h want 3", LO); else n_pass++;
    n_checks++; if (HI !== 32'd1) $display("FAIL divu_hi: got %h want 1", HI); else n_pass++;
  endtask

  task automatic test_divzero;
    int bc; bit chg;
    do_op(3'd4, 32'h1234, 32'd0, bc, chg);
    n_checks++; if (bc != DIV_N) $display("FAIL divz_busy_len: got %0d want %0d", bc, DIV_N); else n_pass++;
    n_checks++; if (HI !== 32'h1234) $display("FAIL divz_hi: got %h want 1234", HI); else n_pass++;
    n_checks++; if (LO !== 32'hFFFF_FFFF) $display("FAIL divz_lo: got %h want ffffffff", LO); else n_pass++;
    do_op(3'd3, 32'hFFFF_FFF0, 32'd0, bc, chg);
    n_checks++; if (HI !== 32'hFFFF_FFF0) $display("FAIL divz_s_hi: got %h want fffffff0", HI); else n_pass++;
    n_checks++; if (LO !== 32'hFFFF_FFFF) $display("FAIL divz_s_lo: got %h want ffffffff", LO); else n_pass++;
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, chg);
    n_checks++; if (LO !== 32'h8000_0000) $display("FAIL divovf_lo: got %h want 80000000", LO); else n_pass++;
    n_checks++; if (HI !== 32'd0) $display("FAIL divovf_hi: got %h want 0", HI); else n_pass++;
  endtask

  task automatic test_stall;
    md_use_D = 1'b0;
    start = 1'b1; md_op = 3'd1; A = 32'd7; B = 32'd9;
    #1;
    n_checks++; if (stall_md !== 1'b0) $display("FAIL stall_no_use: got %b want 0", stall_md); else n_pass++;
    md_use_D = 1'b1;
    #1;
    n_checks++; if (stall_md !== 1'b1) $display("FAIL stall_req_cycle: got %b want 1", stall_md); else n_pass++;
    tick;
    for (int i = 0; i < MULT_N; i++) begin
      start = (i == 1 || i == 2);
      md_op = (i == 1) ? 3'd6 : 3'd3;
      A     = (i == 1) ? 32'h55 : 32'd100;
      B     = 32'd3;
      #1;
      n_checks++; if (stall_md !== 1'b1 || busy !== 1'b1)
        $display("FAIL stall_busy[%0d]: got stall=%b busy=%b want 1/1", i, stall_md, busy); else n_pass++;
      tick;
    end
    start = 1'b0; md_op = 3'd0;
    #1;
    n_checks++; if (stall_md !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_after: got stall=%b busy=%b want 0/0", stall_md, busy); else n_pass++;
    n_checks++; if (LO !== 32'd63 || HI !== 32'd0)
      $display("FAIL ignored_start: got HI=%h LO=%h want 0/3f", HI, LO); else n_pass++;
    tick;
    n_checks++; if (LO !== 32'd63 || busy !== 1'b0)
      $display("FAIL ignored_start_late: got LO=%h busy=%b want 3f/0", LO, busy); else n_pass++;
    md_use_D = 1'b0;
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] lo0;
    lo0 = LO;
    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd5; A = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (stall_md !== 1'b0) $display("FAIL mthi_stall: got %b want 0", stall_md); else n_pass++;
    tick;
    n_checks++; if (HI !== 32'hDEAD_BEEF || LO !== lo0 || busy !== 1'b0)
      $display("FAIL mthi: got HI=%h LO=%h busy=%b want deadbeef/%h/0", HI, LO, busy, lo0); else n_pass++;
    md_op = 3'd6; A = 32'h1;
    #1;
    n_checks++; if (stall_md !== 1'b0) $display("FAIL mtlo_stall: got %b want 0", stall_md); else n_pass++;
    tick;
    n_checks++; if (LO !== 32'h1 || HI !== 32'hDEAD_BEEF || busy !== 1'b0)
      $display("FAIL mtlo: got HI=%h LO=%h busy=%b want deadbeef/1/0", HI, LO, busy); else n_pass++;
    start = 1'b0; md_op = 3'd0; md_use_D = 1'b0;
  endtask

  task automatic test_back_to_back;
    int bc; bit chg;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic [63:0] r;
    eh = HI; el = LO;
    for (int i = 0; i < 4; i++) begin
      op = 3'((i % 4) + 1);
      a = $urandom; b = $urandom;
      r = model(op, a, b, eh, el);
      eh = r[63:32]; el = r[31:0];
      do_op(op, a, b, bc, chg);
      n_checks++; if (bc != latency(op) || HI !== eh || LO !== el)
        $display("FAIL b2b[%0d] op%0d: got busy=%0d HI=%h LO=%h want %0d/%h/%h", i, op, bc, HI, LO, latency(op), eh, el);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int bc; bit chg;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic [63:0] r;
    reset = 1'b0; tick; reset = 1'b1;
    eh = '0; el = '0;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      r = model(op, a, b, eh, el);
      eh = r[63:32]; el = r[31:0];
      do_op(op, a, b, bc, chg);
      n_checks++; if (bc != latency(op) || HI !== eh || LO !== el || (latency(op) != 0 && chg))
        $display("FAIL rand[%0d] op%0d a=%h b=%h: got busy=%0d HI=%h LO=%h want %0d/%h/%h", i, op, a, b, bc, HI, LO, latency(op), eh, el);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; md_op = 3'd5; A = 32'hAAAA_0000; tick;
    md_op = 3'd6; A = 32'h0000_5555; tick;
    md_op = 3'd3; A = 32'd100; B = 32'd7; tick;
    start = 1'b0; md_op = 3'd0;
    tick; tick; tick;
    md_use_D = 1'b1;
    reset = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO); else n_pass++;
    n_checks++; if (stall_md !== 1'b0) $display("FAIL reset_mid_stall: got %b want 0", stall_md); else n_pass++;
    reset = 1'b1;
    repeat (DIV_N + 2) tick;
    n_checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid_late: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO); else n_pass++;
    md_use_D = 1'b0;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_stall;
    test_mthi_mtlo;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
